// File: rtl/sbox_pkg.sv
// Shared AES S-Box definitions: FSM encoding, default sizing and the forward/inverse
// substitution tables used by the arbiter and the switch/LED S-Box top.
package sbox_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOK = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_rom.sv
// Single-port AES S-Box lookup with one cycle of registered latency; inv selects
// the inverse table.
module sbox_rom
  import sbox_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       KEY,
  input  logic [7:0] addr,
  input  logic       inv,
  output logic [7:0] dout
);

  logic [7:0] dout_d;
  logic [7:0] dout_q;

  always_comb begin
    dout_d = inv ? SBOX_INV[addr] : SBOX_FWD[addr];
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      dout_q <= 8'h00;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sbox_arbiter.sv
// Round-robin scheduler sharing one registered S-Box lookup among NREQ byte
// requesters; results return on a single response channel tagged with the requester ID.
module sbox_arbiter
  import sbox_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              CLOCK_50,
  input  logic              KEY,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_inv,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_inv,
  output logic [7:0]        rsp_data,
  output logic              busy,
  output logic [15:0]       xfer_cnt
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     byte_q, byte_d;
  logic           inv_q, inv_d;
  logic [IDW-1:0] id_q, id_d;
  logic [7:0]     rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_inv_q, rsp_inv_d;
  logic [15:0]    cnt_q, cnt_d;

  logic [IDW:0]   pick;
  logic           found;
  logic [IDW-1:0] win;
  logic           accept;
  logic [7:0]     sel_byte;
  logic           sel_inv;
  logic [7:0]     rom_dout;

  // Returns {found, index}: first valid requester after ptr, wrapping modulo NREQ.
  // Scanning from the farthest candidate lets the nearest one overwrite last.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (valid[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    pick   = rr_pick(req_valid, ptr_q);
    found  = pick[IDW];
    win    = pick[IDW-1:0];
    accept = found && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    sel_byte = 8'h00;
    sel_inv  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        sel_byte = req_data[8*i +: 8];
        sel_inv  = req_inv[i];
      end
    end

    req_ready  = accept ? (NREQ'(1) << win) : '0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    byte_d     = byte_q;
    inv_d      = inv_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_inv_d  = rsp_inv_q;
    cnt_d      = cnt_q;

    if (accept) begin
      ptr_d  = win;
      byte_d = sel_byte;
      inv_d  = sel_inv;
      id_d   = win;
    end

    unique case (state_q)
      IDLE: if (accept) state_d = LOOK;
      LOOK: begin
        state_d    = RESP;
        rsp_data_d = rom_dout;
        rsp_id_d   = id_q;
        rsp_inv_d  = inv_q;
      end
      RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = accept ? LOOK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(NREQ - 1);
      byte_q     <= 8'h00;
      inv_q      <= 1'b0;
      id_q       <= '0;
      rsp_data_q <= 8'h00;
      rsp_id_q   <= '0;
      rsp_inv_q  <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      byte_q     <= byte_d;
      inv_q      <= inv_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_inv_q  <= rsp_inv_d;
      cnt_q      <= cnt_d;
    end
  end

  // The ROM sees the byte being accepted this cycle so its output is ready in LOOK.
  sbox_rom u_rom (
    .CLOCK_50 (CLOCK_50),
    .KEY      (KEY),
    .addr     (byte_d),
    .inv      (inv_d),
    .dout     (rom_dout)
  );

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_inv   = rsp_inv_q;
  assign rsp_data  = rsp_data_q;
  assign xfer_cnt  = cnt_q;

endmodule
